// File: rtl/verinject_checker_pkg.sv
// Shared types and helpers for the lockstep checker: FSM state encoding,
// outcome codes and the saturating-increment helper.
package verinject_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_DIVERGED  = 2'd2,
        ST_RECOVERED = 2'd3
    } state_e;

    localparam logic [1:0] OUTCOME_MASKED     = 2'd0;
    localparam logic [1:0] OUTCOME_TRANSIENT  = 2'd1;
    localparam logic [1:0] OUTCOME_PERSISTENT = 2'd2;
    localparam logic [1:0] OUTCOME_IDLE       = 2'd3;

    // Increment that sticks at limit instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

    // Index width that stays at least one bit for a single channel.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] outcome_of(input logic [1:0] state);
        case (state)
            ST_ARMED:     return OUTCOME_MASKED;
            ST_DIVERGED:  return OUTCOME_PERSISTENT;
            ST_RECOVERED: return OUTCOME_TRANSIENT;
            default:      return OUTCOME_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/verinject_lockstep_checker_if.sv
// Compare bus between the golden/injected design pair and the lockstep checker.
interface verinject_lockstep_checker_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CYCLE_W  = 48,
    parameter int unsigned CNT_W    = 16
);
    import verinject_checker_pkg::*;

    localparam int unsigned CH_W = idx_w(CHANNELS);

    logic                        enable;
    logic                        clear;
    logic [CHANNELS*WIDTH-1:0]   golden;
    logic [CHANNELS*WIDTH-1:0]   injected;
    logic [CYCLE_W-1:0]          cycle_number;

    logic [CHANNELS-1:0]         mismatch_now;
    logic [CHANNELS-1:0]         mismatch_sticky;
    logic [CHANNELS*CNT_W-1:0]   mismatch_count;
    logic                        first_valid;
    logic [CYCLE_W-1:0]          first_cycle;
    logic [CH_W-1:0]             first_channel;
    logic [WIDTH-1:0]            first_xor;
    logic [1:0]                  outcome;

    modport master (
        output enable, clear, golden, injected, cycle_number,
        input  mismatch_now, mismatch_sticky, mismatch_count,
               first_valid, first_cycle, first_channel, first_xor, outcome
    );

    modport slave (
        input  enable, clear, golden, injected, cycle_number,
        output mismatch_now, mismatch_sticky, mismatch_count,
               first_valid, first_cycle, first_channel, first_xor, outcome
    );

endinterface

// File: rtl/verinject_checker_channel.sv
// One compared channel: combinational diff, registered mismatch_now/sticky
// and a saturating mismatch counter.
module verinject_checker_channel
    import verinject_checker_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_compare,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_golden,
    input  logic [WIDTH-1:0] i_injected,
    output logic             o_miss_c,
    output logic [WIDTH-1:0] o_diff_c,
    output logic             o_mismatch_now,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic             r_now;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    assign o_diff_c = i_golden ^ i_injected;
    assign o_miss_c = |o_diff_c;

    // Clear beats compare; disabled cycles leave everything frozen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_now    <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_now    <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (i_compare) begin
            r_now    <= o_miss_c;
            r_sticky <= r_sticky | o_miss_c;
            if (o_miss_c) begin
                r_count <= CNT_W'(sat_inc(32'(r_count), CNT_MAX));
            end
        end
    end

    assign o_mismatch_now = r_now;
    assign o_sticky       = r_sticky;
    assign o_count        = r_count;

endmodule

// File: rtl/verinject_lockstep_checker.sv
// Lockstep comparator between a golden instance and its injected copy.
// Optional per-mismatch/transition logging with VERINJECT_CHECKER_DISPLAY_EN.
module verinject_lockstep_checker
    import verinject_checker_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned CYCLE_W        = 48,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned RECOVER_CYCLES = 8
) (
    input logic                     clock,
    input logic                     reset_n,
    verinject_lockstep_checker_if.slave bus
);

    localparam int unsigned CH_W  = idx_w(CHANNELS);
    localparam int unsigned RUN_W = $clog2(RECOVER_CYCLES + 1);

    localparam logic [1:0] S_IDLE      = 2'(ST_IDLE);
    localparam logic [1:0] S_ARMED     = 2'(ST_ARMED);
    localparam logic [1:0] S_DIVERGED  = 2'(ST_DIVERGED);
    localparam logic [1:0] S_RECOVERED = 2'(ST_RECOVERED);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [RUN_W-1:0]    r_run;
    logic [RUN_W-1:0]    w_run_nxt;
    logic [RUN_W-1:0]    w_run_inc;
    logic                w_capture;
    logic                w_compare;
    logic                w_any;
    logic [CHANNELS-1:0] w_miss;
    logic [WIDTH-1:0]    w_diff [CHANNELS];
    logic [CH_W-1:0]     w_first_idx;
    logic [WIDTH-1:0]    w_first_xor;

    logic                r_first_valid;
    logic [CYCLE_W-1:0]  r_first_cycle;
    logic [CH_W-1:0]     r_first_channel;
    logic [WIDTH-1:0]    r_first_xor;
    logic [1:0]          r_outcome;

    assign w_compare = bus.enable && (r_state != S_IDLE);

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        verinject_checker_channel #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_ch (
            .clock          (clock),
            .reset_n        (reset_n),
            .i_compare      (w_compare),
            .i_clear        (bus.clear),
            .i_golden       (bus.golden[c*WIDTH +: WIDTH]),
            .i_injected     (bus.injected[c*WIDTH +: WIDTH]),
            .o_miss_c       (w_miss[c]),
            .o_diff_c       (w_diff[c]),
            .o_mismatch_now (bus.mismatch_now[c]),
            .o_sticky       (bus.mismatch_sticky[c]),
            .o_count        (bus.mismatch_count[c*CNT_W +: CNT_W])
        );
    end

    assign w_any = |w_miss;

    // Lowest-index mismatching channel wins.
    always_comb begin
        w_first_idx = '0;
        w_first_xor = '0;
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (w_miss[c]) begin
                w_first_idx = CH_W'(c);
                w_first_xor = w_diff[c];
            end
        end
    end

    assign w_run_inc = RUN_W'(sat_inc(32'(r_run), 32'(RECOVER_CYCLES)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_run     <= '0;
            r_outcome <= OUTCOME_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_outcome <= outcome_of(w_state_nxt);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_capture   = 1'b0;
        if (bus.clear) begin
            w_state_nxt = bus.enable ? S_ARMED : S_IDLE;
            w_run_nxt   = '0;
        end else if (bus.enable) begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if (w_any) begin
                        w_state_nxt = S_DIVERGED;
                        w_capture   = 1'b1;
                        w_run_nxt   = '0;
                    end
                end
                S_DIVERGED: begin
                    if (w_any) begin
                        w_run_nxt = '0;
                    end else begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_W'(RECOVER_CYCLES)) begin
                            w_state_nxt = S_RECOVERED;
                        end
                    end
                end
                S_RECOVERED: begin
                    if (w_any) begin
                        w_state_nxt = S_DIVERGED;
                        w_run_nxt   = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // First divergence is latched once per armed period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_first_valid   <= 1'b0;
            r_first_cycle   <= '0;
            r_first_channel <= '0;
            r_first_xor     <= '0;
        end else if (bus.clear) begin
            r_first_valid   <= 1'b0;
            r_first_cycle   <= '0;
            r_first_channel <= '0;
            r_first_xor     <= '0;
        end else if (w_capture) begin
            r_first_valid   <= 1'b1;
            r_first_cycle   <= bus.cycle_number;
            r_first_channel <= w_first_idx;
            r_first_xor     <= w_first_xor;
        end
    end

    assign bus.first_valid   = r_first_valid;
    assign bus.first_cycle   = r_first_cycle;
    assign bus.first_channel = r_first_channel;
    assign bus.first_xor     = r_first_xor;
    assign bus.outcome       = r_outcome;

`ifdef VERINJECT_CHECKER_DISPLAY_EN
    always_ff @(posedge clock) begin
        if (reset_n && !bus.clear && w_compare) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (w_miss[c]) begin
                    $display("verinject_checker: cycle %0h ch %0d golden %h injected %h xor %h",
                             bus.cycle_number, c, bus.golden[c*WIDTH +: WIDTH],
                             bus.injected[c*WIDTH +: WIDTH], w_diff[c]);
                end
            end
        end
        if (reset_n && (w_state_nxt != r_state)) begin
            $display("verinject_checker: cycle %0h state %0d -> %0d",
                     bus.cycle_number, r_state, w_state_nxt);
        end
    end
`else
    // Silent build: no system tasks.
`endif

endmodule
